// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for a picorv32-native memory slave.
// m0 (CPU) and m1 (secondary engine) share one slave through a registered
// grant. Only one transaction is outstanding at a time, and a watchdog
// completes a hung transaction with an error word.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF,
  parameter bit          M0_PRIORITY    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_pulse,
  output logic [31:0] timeout_addr
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Watchdog fires when the counter reaches the last allowed BUSY cycle.
  localparam bit          LP_WDOG_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] LP_WDOG_LAST = LP_WDOG_EN ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

  state_t      r_state, w_state_nxt;
  logic [1:0]  r_grant, w_grant_nxt;
  logic        r_last,  w_last_nxt;       // 0: m0 served last, 1: m1 served last
  logic [31:0] r_wdog,  w_wdog_nxt;
  logic [31:0] r_timeout_addr, w_timeout_addr_nxt;

  logic        w_pick_m1;
  logic        w_g_valid;
  logic        w_g_instr;
  logic [31:0] w_g_addr;
  logic [31:0] w_g_wdata;
  logic [3:0]  w_g_wstrb;
  logic [1:0]  w_ready;
  logic [31:0] w_rdata;

  // Saturating watchdog increment so a disabled watchdog never wraps.
  function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Granted master's request fields, selected by the registered grant.
  always_comb begin
    w_g_valid = r_grant[1] ? m1_valid : m0_valid;
    w_g_instr = r_grant[1] ? m1_instr : m0_instr;
    w_g_addr  = r_grant[1] ? m1_addr  : m0_addr;
    w_g_wdata = r_grant[1] ? m1_wdata : m0_wdata;
    w_g_wstrb = r_grant[1] ? m1_wstrb : m0_wstrb;
  end

  // Arbitration: single requester wins; a tie goes to m0 under fixed
  // priority, otherwise to the master that was not served last.
  always_comb begin
    w_pick_m1 = m1_valid && (!m0_valid || (!M0_PRIORITY && !r_last));
  end

  // Next-state and output decode; reset suppresses all slave/master activity.
  always_comb begin
    w_state_nxt        = r_state;
    w_grant_nxt        = r_grant;
    w_last_nxt         = r_last;
    w_wdog_nxt         = r_wdog;
    w_timeout_addr_nxt = r_timeout_addr;
    s_valid            = 1'b0;
    s_instr            = 1'b0;
    s_addr             = 32'd0;
    s_wdata            = 32'd0;
    s_wstrb            = 4'd0;
    w_ready            = 2'b00;
    w_rdata            = 32'd0;
    timeout_pulse      = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_IDLE: begin
          if (m0_valid || m1_valid) begin
            w_state_nxt = ST_BUSY;
            w_grant_nxt = w_pick_m1 ? 2'b10 : 2'b01;
            w_wdog_nxt  = 32'd0;
          end
        end
        ST_BUSY: begin
          s_valid = w_g_valid;
          s_instr = w_g_instr;
          s_addr  = w_g_addr;
          s_wdata = w_g_wdata;
          s_wstrb = w_g_wstrb;
          if (!w_g_valid) begin
            // Master withdrew its request: abandon without a ready.
            w_state_nxt = ST_IDLE;
            w_grant_nxt = 2'b00;
          end else if (s_ready) begin
            w_ready     = r_grant;
            w_rdata     = s_rdata;
            w_last_nxt  = r_grant[1];
            w_grant_nxt = 2'b00;
            w_state_nxt = ST_IDLE;
          end else if (LP_WDOG_EN && (r_wdog == LP_WDOG_LAST)) begin
            // Slave hung: complete to the master with the error word.
            s_valid            = 1'b0;
            w_ready            = r_grant;
            w_rdata            = ERR_RDATA;
            timeout_pulse      = 1'b1;
            w_timeout_addr_nxt = w_g_addr;
            w_last_nxt         = r_grant[1];
            w_grant_nxt        = 2'b00;
            w_state_nxt        = ST_IDLE;
          end else begin
            w_wdog_nxt = f_sat_inc(r_wdog);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = 2'b00;
        end
      endcase
    end
  end

  // State, grant, round-robin history, watchdog and sticky timeout address.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_grant        <= 2'b00;
      r_last         <= 1'b1;
      r_wdog         <= 32'd0;
      r_timeout_addr <= 32'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_grant        <= w_grant_nxt;
      r_last         <= w_last_nxt;
      r_wdog         <= w_wdog_nxt;
      r_timeout_addr <= w_timeout_addr_nxt;
    end
  end

  assign m0_ready     = w_ready[0];
  assign m1_ready     = w_ready[1];
  assign m0_rdata     = w_ready[0] ? w_rdata : 32'd0;
  assign m1_rdata     = w_ready[1] ? w_rdata : 32'd0;
  assign grant        = r_grant;
  assign timeout_addr = r_timeout_addr;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: a round-robin instance (watchdog 8)
// and a fixed-priority instance (watchdog 5), each driven by its own pair of
// protocol-following masters and a random slave, checked every cycle against
// a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
  localparam int NCYC = 3000;

  logic        clk;
  logic        rst;

  logic        mv  [2][2];
  logic        mi  [2][2];
  logic [31:0] ma  [2][2];
  logic [31:0] mw  [2][2];
  logic [3:0]  ms  [2][2];
  logic        mr  [2][2];
  logic [31:0] mrd [2][2];
  logic        sr  [2];
  logic [31:0] srd [2];
  logic        sv  [2];
  logic        si  [2];
  logic [31:0] sa  [2];
  logic [31:0] swd [2];
  logic [3:0]  sws [2];
  logic [1:0]  gr  [2];
  logic        tp  [2];
  logic [31:0] ta  [2];

  int n_tests;
  int n_fail;

  // Reference model state per instance.
  int          owner [2];   // 0 none, 1 m0, 2 m1
  int          lastm [2];   // index of master served last
  int          waited[2];   // BUSY cycles already spent without completion
  logic [31:0] mta   [2];   // sticky timeout address
  bit          rdy_prev [2][2];
  bit          pend  [2][2];
  int          tmo   [2];
  bit          prio  [2];

  mem_bus_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(ERR), .M0_PRIORITY(1'b0)) u_rr (
    .clk(clk), .reset(rst),
    .m0_valid(mv[0][0]), .m0_instr(mi[0][0]), .m0_addr(ma[0][0]), .m0_wdata(mw[0][0]),
    .m0_wstrb(ms[0][0]), .m0_ready(mr[0][0]), .m0_rdata(mrd[0][0]),
    .m1_valid(mv[0][1]), .m1_instr(mi[0][1]), .m1_addr(ma[0][1]), .m1_wdata(mw[0][1]),
    .m1_wstrb(ms[0][1]), .m1_ready(mr[0][1]), .m1_rdata(mrd[0][1]),
    .s_valid(sv[0]), .s_instr(si[0]), .s_addr(sa[0]), .s_wdata(swd[0]), .s_wstrb(sws[0]),
    .s_ready(sr[0]), .s_rdata(srd[0]),
    .grant(gr[0]), .timeout_pulse(tp[0]), .timeout_addr(ta[0])
  );

  mem_bus_arbiter #(.TIMEOUT_CYCLES(5), .ERR_RDATA(ERR), .M0_PRIORITY(1'b1)) u_fp (
    .clk(clk), .reset(rst),
    .m0_valid(mv[1][0]), .m0_instr(mi[1][0]), .m0_addr(ma[1][0]), .m0_wdata(mw[1][0]),
    .m0_wstrb(ms[1][0]), .m0_ready(mr[1][0]), .m0_rdata(mrd[1][0]),
    .m1_valid(mv[1][1]), .m1_instr(mi[1][1]), .m1_addr(ma[1][1]), .m1_wdata(mw[1][1]),
    .m1_wstrb(ms[1][1]), .m1_ready(mr[1][1]), .m1_rdata(mrd[1][1]),
    .s_valid(sv[1]), .s_instr(si[1]), .s_addr(sa[1]), .s_wdata(swd[1]), .s_wstrb(sws[1]),
    .s_ready(sr[1]), .s_rdata(srd[1]),
    .grant(gr[1]), .timeout_pulse(tp[1]), .timeout_addr(ta[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Predict one cycle of one instance from the current inputs, compare, then
  // advance the model.
  task automatic model_cycle(input int d);
    logic [1:0]  e_gr;
    logic        e_sv, e_si, e_tp;
    logic [31:0] e_sa, e_swd, e_rd;
    logic [3:0]  e_sws;
    bit          e_rdy [2];
    int          g;
    int          pick;
    int          own_now;
    string       p;
    e_gr = 2'b00; e_sv = 1'b0; e_si = 1'b0; e_tp = 1'b0;
    e_sa = 32'd0; e_swd = 32'd0; e_sws = 4'd0; e_rd = 32'd0;
    e_rdy[0] = 1'b0; e_rdy[1] = 1'b0;
    own_now = owner[d];
    p = (d == 0) ? "rr" : "fp";
    if (own_now == 0) begin
      if (mv[d][0] || mv[d][1]) begin
        if (mv[d][0] && mv[d][1]) pick = prio[d] ? 0 : 1 - lastm[d];
        else                      pick = mv[d][1] ? 1 : 0;
        owner[d]  = pick + 1;
        waited[d] = 0;
      end
    end else begin
      g     = own_now - 1;
      e_gr  = (g == 1) ? 2'b10 : 2'b01;
      e_sv  = mv[d][g];
      e_si  = mi[d][g];
      e_sa  = ma[d][g];
      e_swd = mw[d][g];
      e_sws = ms[d][g];
      if (!mv[d][g]) begin
        owner[d] = 0;
      end else if (sr[d]) begin
        e_rdy[g] = 1'b1; e_rd = srd[d]; lastm[d] = g; owner[d] = 0;
      end else if (tmo[d] != 0 && waited[d] == tmo[d] - 1) begin
        e_sv = 1'b0; e_rdy[g] = 1'b1; e_rd = ERR; e_tp = 1'b1;
        lastm[d] = g; owner[d] = 0;
      end else begin
        waited[d]++;
      end
    end
    check({p, " grant"},         32'(gr[d]),  32'(e_gr));
    check({p, " s_valid"},       32'(sv[d]),  32'(e_sv));
    check({p, " s_instr"},       32'(si[d]),  32'(e_si));
    check({p, " s_addr"},        sa[d],       e_sa);
    check({p, " s_wdata"},       swd[d],      e_swd);
    check({p, " s_wstrb"},       32'(sws[d]), 32'(e_sws));
    check({p, " m0_ready"},      32'(mr[d][0]), 32'(e_rdy[0]));
    check({p, " m1_ready"},      32'(mr[d][1]), 32'(e_rdy[1]));
    check({p, " timeout_pulse"}, 32'(tp[d]),  32'(e_tp));
    check({p, " timeout_addr"},  ta[d],       mta[d]);
    for (int m = 0; m < 2; m++) begin
      if (e_rdy[m])             check($sformatf("%s m%0d_rdata", p, m), mrd[d][m], e_rd);
      else if (own_now != m + 1) check($sformatf("%s m%0d_rdata idle", p, m), mrd[d][m], 32'd0);
    end
    if (e_tp) mta[d] = e_sa;
    rdy_prev[d][0] = e_rdy[0];
    rdy_prev[d][1] = e_rdy[1];
  endtask

  task automatic model_reset(input int d);
    owner[d] = 0; lastm[d] = 1; waited[d] = 0; mta[d] = 32'd0;
    rdy_prev[d][0] = 1'b0; rdy_prev[d][1] = 1'b0;
  endtask

  // Masters hold a request until they see ready; a rare withdrawal exercises
  // the protocol-violation path.
  task automatic drive_inputs(input int d, input int req_p, input int rdy_p);
    for (int m = 0; m < 2; m++) begin
      if (rdy_prev[d][m]) pend[d][m] = 1'b0;
      else if (pend[d][m] && $urandom_range(0, 199) == 0) pend[d][m] = 1'b0;
      if (!pend[d][m] && $urandom_range(0, 99) < req_p) begin
        pend[d][m] = 1'b1;
        ma[d][m] = $urandom & 32'hFFFF_FFFC;
        mw[d][m] = $urandom;
        ms[d][m] = 4'($urandom_range(0, 15));
        mi[d][m] = 1'($urandom_range(0, 1));
      end
      mv[d][m] = pend[d][m];
    end
    sr[d]  = ($urandom_range(0, 99) < rdy_p);
    srd[d] = $urandom;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    tmo[0] = 8; tmo[1] = 5;
    prio[0] = 1'b0; prio[1] = 1'b1;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      model_reset(d);
      sr[d] = 1'b0; srd[d] = 32'd0;
      for (int m = 0; m < 2; m++) begin
        pend[d][m] = 1'b0; mv[d][m] = 1'b0; mi[d][m] = 1'b0;
        ma[d][m] = 32'd0; mw[d][m] = 32'd0; ms[d][m] = 4'd0;
      end
    end
    repeat (3) @(posedge clk);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      int rdy_p;
      int req_p;
      @(posedge clk);
      #1;
      rst   = (cyc % 311 == 200);
      rdy_p = ((cyc / 250) % 2 == 1) ? 5 : 45;
      req_p = ((cyc / 500) % 2 == 1) ? 95 : 60;
      if (cyc < 2) req_p = 0;
      for (int d = 0; d < 2; d++) drive_inputs(d, req_p, rdy_p);
      #1;
      for (int d = 0; d < 2; d++) begin
        if (rst) model_reset(d);
        else     model_cycle(d);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
